// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational log-stage mux shifter that moves x by 0..STEP bits in one of four modes.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 1
) (
  input  logic [N-1:0]             x,
  input  op_t                      op,
  input  logic [$clog2(STEP):0]    amount,
  output logic [N-1:0]             y
);

  localparam int STAGES = $clog2(STEP) + 1;

  // Fixed-distance shift; ROL by exactly N degenerates to identity, which is correct.
  function automatic logic [N-1:0] shift_const(input logic [N-1:0] v, input op_t o, input int s);
    case (o)
      OP_SLL:  return v << s;
      OP_SRL:  return v >> s;
      OP_SRA:  return $signed(v) >>> s;
      OP_ROL:  return (v << s) | (v >> (N - s));
      default: return v;
    endcase
  endfunction

  logic [N-1:0] stage [0:STAGES];

  assign stage[0] = x;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign stage[i+1] = amount[i] ? shift_const(stage[i], op, 1 << i) : stage[i];
  end

  assign y = stage[STAGES];

endmodule

// File: rtl/n_bit_iter_shifter.sv
// Multi-cycle shifter: accepts one request, shifts up to STEP bits per clock, then holds the result.
module n_bit_iter_shifter
  import shift_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_shamt,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 busy
);

  localparam int SHW = $clog2(N);
  localparam int AW  = $clog2(STEP) + 1;

  state_t         state;
  op_t            op;
  logic [N-1:0]   acc;
  logic [SHW-1:0] cnt;
  logic [AW-1:0]  k;
  logic [SHW-1:0] cnt_next;
  logic [N-1:0]   step_y;

  assign in_ready = (state == S_IDLE) && rst_n;
  assign busy     = (state != S_IDLE);

  // k = min(STEP, cnt); cnt never exceeds N-1, so k always fits back into SHW bits.
  always_comb begin
    k = '0;
    if (32'(cnt) >= STEP) k = AW'(STEP);
    else                  k = AW'(cnt);
  end

  assign cnt_next = cnt - SHW'(k);

  shift_step_unit #(
    .N    (N),
    .STEP (STEP)
  ) u_step (
    .x      (acc),
    .op     (op),
    .amount (k),
    .y      (step_y)
  );

  // out_data is its own register so the last result survives the next capture into acc.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op        <= OP_SLL;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc <= in_data;
            op  <= op_t'(in_op);
            cnt <= in_shamt;
            if (in_shamt == '0) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc <= step_y;
          cnt <= cnt_next;
          if (cnt_next == '0) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_data  <= step_y;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n_bit_iter_shifter.sv
// Directed bench for n_bit_iter_shifter: one STEP=1 and one STEP=4 instance sharing stimulus.
module tb_n_bit_iter_shifter;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_ready;

  logic        in_ready1, out_valid1, busy1;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out_data1, out_data4;

  logic        obs_in_ready, obs_out_valid, obs_busy;
  logic [31:0] obs_out_data;

  int tests_run;
  int tests_failed;

  n_bit_iter_shifter #(.N(32), .STEP(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && !sel),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .busy      (busy1)
  );

  n_bit_iter_shifter #(.N(32), .STEP(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && sel),
    .in_ready  (in_ready4),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .busy      (busy4)
  );

  assign obs_in_ready  = sel ? in_ready4  : in_ready1;
  assign obs_out_valid = sel ? out_valid4 : out_valid1;
  assign obs_busy      = sel ? busy4      : busy1;
  assign obs_out_data  = sel ? out_data4  : out_data1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits (bounded) for in_ready, and leaves time just after the accept edge.
  task automatic sendRequest(input logic s, input logic [31:0] data, input logic [4:0] shamt,
                             input logic [1:0] op);
    int guard;
    sel      = s;
    in_data  = data;
    in_shamt = shamt;
    in_op    = op;
    in_valid = 1'b1;
    #1;
    guard = 0;
    while (!obs_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("accept_ready", {31'b0, obs_in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    in_shamt = 5'd17;
    in_op    = SLL;
  endtask

  // Measures latency from the accept edge, checks data and busy, then completes the output handshake.
  task automatic collectResult(input string tag, input logic [31:0] exp_data, input int exp_lat);
    int cyc;
    int busy_miss;
    cyc       = 1;
    busy_miss = 0;
    while (!obs_out_valid && cyc < 100) begin
      if (!obs_busy) busy_miss++;
      tick();
      cyc++;
    end
    if (!obs_busy) busy_miss++;
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    checkOutput({tag, "_data"}, obs_out_data, exp_data);
    checkOutput({tag, "_busy"}, 32'(busy_miss), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {31'b0, obs_out_valid}, 32'd0);
    checkOutput({tag, "_ready_back"}, {31'b0, obs_in_ready}, 32'd1);
    checkOutput({tag, "_data_hold"}, obs_out_data, exp_data);
  endtask

  task automatic applyStimulus(input string tag, input logic s, input logic [31:0] data,
                               input logic [4:0] shamt, input logic [1:0] op,
                               input logic [31:0] exp_data, input int exp_lat);
    sendRequest(s, data, shamt, op);
    collectResult(tag, exp_data, exp_lat);
  endtask

  initial begin
    int vmiss;
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = SLL;
    out_ready = 1'b0;

    repeat (3) tick();
    checkOutput("rst_in_ready1", {31'b0, in_ready1}, 32'd0);
    checkOutput("rst_in_ready4", {31'b0, in_ready4}, 32'd0);
    checkOutput("rst_out_valid", {30'b0, out_valid1, out_valid4}, 32'd0);
    checkOutput("rst_busy", {30'b0, busy1, busy4}, 32'd0);
    checkOutput("rst_out_data1", out_data1, 32'h0);
    checkOutput("rst_out_data4", out_data4, 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", {30'b0, in_ready1, in_ready4}, 32'd3);

    // STEP=1: latency is shamt+1 cycles after accept.
    applyStimulus("s1_sll5",  1'b0, 32'h0000_0001, 5'd5,  SLL, 32'h0000_0020, 6);
    applyStimulus("s1_sra31", 1'b0, 32'h8000_0000, 5'd31, SRA, 32'hFFFF_FFFF, 32);
    applyStimulus("s1_srl31", 1'b0, 32'h8000_0000, 5'd31, SRL, 32'h0000_0001, 32);
    applyStimulus("s1_rol4",  1'b0, 32'h8000_0001, 5'd4,  ROL, 32'h0000_0018, 5);
    applyStimulus("s1_rol0",  1'b0, 32'h1234_5678, 5'd0,  ROL, 32'h1234_5678, 1);

    // STEP=4: latency is ceil(shamt/4)+1 cycles after accept.
    applyStimulus("s4_srl7",  1'b1, 32'hF000_0000, 5'd7,  SRL, 32'h01E0_0000, 3);
    applyStimulus("s4_rol4",  1'b1, 32'h8000_0001, 5'd4,  ROL, 32'h0000_0018, 2);
    applyStimulus("s4_sra3",  1'b1, 32'h8000_0000, 5'd3,  SRA, 32'hF000_0000, 2);
    applyStimulus("s4_sra4p", 1'b1, 32'h7000_0000, 5'd4,  SRA, 32'h0700_0000, 2);
    applyStimulus("s4_sll31", 1'b1, 32'hFFFF_FFFF, 5'd31, SLL, 32'h8000_0000, 9);
    applyStimulus("s4_rol0",  1'b1, 32'hCAFE_F00D, 5'd0,  ROL, 32'hCAFE_F00D, 1);

    // Backpressure: result held, new request ignored until the cycle after the handshake.
    sendRequest(1'b0, 32'h0000_0003, 5'd2, SLL);
    repeat (2) tick();
    checkOutput("bp_valid", {31'b0, obs_out_valid}, 32'd1);
    in_data  = 32'h0000_000A;
    in_shamt = 5'd1;
    in_op    = SLL;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_hold_data", obs_out_data, 32'h0000_000C);
      checkOutput("bp_ready_low", {31'b0, obs_in_ready}, 32'd0);
      checkOutput("bp_hold_valid", {31'b0, obs_out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp_hs_valid", {31'b0, obs_out_valid}, 32'd0);
    checkOutput("bp_hs_busy", {31'b0, obs_busy}, 32'd0);
    checkOutput("bp_hs_data", obs_out_data, 32'h0000_000C);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_next_busy", {31'b0, obs_busy}, 32'd1);
    collectResult("bp_next", 32'h0000_0014, 2);

    // Reset in the middle of a long STEP=1 shift.
    sendRequest(1'b0, 32'h0000_0001, 5'd20, SLL);
    repeat (4) tick();
    checkOutput("mid_busy", {31'b0, obs_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {31'b0, obs_in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {31'b0, obs_out_valid}, 32'd0);
    checkOutput("mid_rst_data", obs_out_data, 32'h0);
    checkOutput("mid_rst_busy", {31'b0, obs_busy}, 32'd0);
    checkOutput("mid_rst_ready_hi", {31'b0, obs_in_ready}, 32'd1);
    vmiss = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (obs_out_valid || obs_busy) vmiss++;
    end
    checkOutput("mid_rst_no_result", 32'(vmiss), 32'd0);

    applyStimulus("post_rst_srl", 1'b0, 32'hA5A5_0000, 5'd8, SRL, 32'h00A5_A500, 9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/n_bit_iter_shifter.md
Name: n_bit_iter_shifter

Overview:
Parametrised multi-cycle shifter, the successor to the fixed shift-left-by-one block. It supports variable shift amount and four modes: SLL, SRL, SRA and ROL. It shifts up to STEP bits per clock, trading latency against area. It serves the RISC-V datapath for shift instructions and uses a valid/ready handshake on both input and output.

Parameters:
N, 32, data width; power of 2, N >= 2
STEP, 1, maximum bits shifted per cycle; power of 2, 1 <= STEP <= N
SHW (localparam), $clog2(N), shift-amount width

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  request valid
in_ready  output  1  block can accept a request (combinational: state==IDLE && rst_n)
in_data  input  N  operand
in_shamt  input  SHW  shift amount 0..N-1
in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  N  result; registered
busy  output  1  state != IDLE

Behaviour:
- Reset, when rst_n is low at a rising edge:
  - state=IDLE, out_valid=0, out_data=0, remaining count=0, busy=0.
  - in_ready=0 while rst_n is low.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into acc, latch op, set cnt=in_shamt.
  - Next state is DONE if in_shamt==0, else SHIFT.
  - in_data, in_shamt and in_op need only be stable in the accept cycle.
- SHIFT, each cycle:
  - k=min(STEP,cnt).
  - acc <= op(acc,k); cnt <= cnt-k.
  - If cnt-k==0, go to DONE.
- DONE:
  - out_valid=1, out_data=acc.
  - On out_ready, go to IDLE and drop out_valid next cycle.
  - out_data holds stable while out_valid && !out_ready.
- Latency:
  - SHIFT occupies ceil(shamt/STEP) cycles.
  - out_valid first asserts in cycle ceil(shamt/STEP)+1 after the acceptance edge.
  - shamt=0 gives out_valid in cycle 1.
- Throughput: one request in flight. in_ready is low in SHIFT and DONE, and in_valid is ignored there. The earliest next accept is the cycle after the out_ready handshake.
- Mode rules:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: MSB-replicate. acc[N-1] is invariant, so the sign stays correct across steps.
  - ROL: bits leaving the MSB re-enter at the LSB.
  - Results are always exactly N bits; no carry-out.
- out_data between transactions retains the last result; only meaningful while out_valid=1.
- Reset mid-operation (SHIFT or DONE): the operation is abandoned. Next state is IDLE with out_valid=0 and out_data=0; no result is emitted.
- Simultaneous out_ready and in_valid in DONE: only the output handshake completes; the input is not accepted that cycle.
- STEP=N: every nonzero shift completes in 1 SHIFT cycle.

Decomposition:
- Shared package shift_pkg:
  - op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROL=2'b11
  - state encodings: S_IDLE, S_SHIFT, S_DONE
- Sub-module shift_step_unit, purely combinational:
  - inputs: N-bit x, op, amount 0..STEP
  - output: y
  - implemented as a log2(STEP)+1 stage mux shifter
- The top level holds the FSM, acc, cnt and the handshake logic.

Test Plan:
- N=32, STEP=1: SLL 0x0000_0001, shamt=5 -> out_data=0x0000_0020; out_valid first high in cycle 6 after accept; busy high cycles 1-6.
- N=32, STEP=1: SRA 0x8000_0000, shamt=31 -> 0xFFFF_FFFF. Repeat with SRL -> 0x0000_0001.
- N=32, STEP=4: SRL 0xF000_0000, shamt=7 -> 0x01E0_0000; 2 SHIFT cycles, out_valid in cycle 3.
- ROL 0x8000_0001, shamt=4 -> 0x0000_0018. ROL 0x1234_5678, shamt=0 -> 0x1234_5678 with out_valid in cycle 1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1.
  - Response: out_data stable, in_ready=0, no second capture. Release out_ready; the new request is accepted the cycle after the handshake.
- Reset: drop rst_n for one edge mid-SHIFT (STEP=1, shamt=20) -> next cycle state IDLE, out_valid=0, out_data=0, busy=0, in_ready=1 once rst_n is high.
